mano_timing_sequencer: RTL and testbench
========================================

Name: mano_timing_sequencer

Overview:
- Timing and control sequencer for the basic computer.
- Owns the 3-bit sequence counter (SC), the start/stop flip-flop S, the interrupt-enable flip-flop IEN and the interrupt-cycle flip-flop R.
- Generates the one-hot timing signals T[7:0] and decodes IR into D[7:0], I and B[11:0].
- These outputs feed every control-function block, including PC, AR, AC and memory control.

Parameters:
- START_RUN, 1, reset value of S (1 = run after reset, 0 = wait for start pulse)
- IEN_RESET, 0, reset value of IEN

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ir  input  16  instruction register contents, loaded by the datapath at T2
- fgi  input  1  input flag
- fgo  input  1  output flag
- stall  input  1  memory wait; freezes SC while high
- start  input  1  single-cycle pulse; sets S
- T  output  8  one-hot timing signals; all zero when halted
- D  output  8  one-hot decode of ir[14:12]
- I  output  1  ir[15]
- B  output  12  ir[11:0]
- R  output  1  interrupt-cycle flag
- IEN  output  1  interrupt enable
- S  output  1  run flag
- sc_clr  output  1  SC clears at the next enabled edge

Behaviour:
- Reset (rst_n low, asynchronous):
  - SC=0, R=0, S=START_RUN, IEN=IEN_RESET.
  - T=00000001 if S=1, otherwise 00000000.
- Outputs:
  - T[k] = S & (SC==k).
  - D, I and B are purely combinational from ir.
- SC advance:
  - SC updates only when S=1 and stall=0. Otherwise SC, R and IEN hold.
  - Exception: start still sets S while S=0.
- sc_clr is asserted, combinationally, when any of the following holds:
  - R&T2
  - D0&T5, D1&T5, D2&T5, D5&T5
  - D3&T4, D4&T4
  - D6&T6
  - D7&T3 (register-reference and I/O instructions)
- SC next value:
  - 0 if sc_clr.
  - SC+1 otherwise, wrapping 7->0. The wrap is unreachable for legal code; verification flags it as an assertion failure.
- Interrupt entry:
  - Condition: at an enabled edge with ~T0&~T1&~T2 & IEN & (fgi|fgo) & ~R.
  - Action: R<=1.
  - R is sampled by the datapath starting at the next T0 of the interrupt cycle.
- Interrupt cycle:
  - During R&T2 (enabled edge): R<=0, IEN<=0, SC<=0.
  - T0 and T1 of the interrupt cycle do not change R.
- I/O instructions, active when D7&I&T3 at an enabled edge:
  - B[7] (ION): IEN<=1.
  - B[6] (IOF): IEN<=0.
  - If both bits are set, IOF wins.
- HLT: D7&~I&T3&B[0] at an enabled edge sets S<=0 and SC<=0.
  - T goes all-zero on the following cycle.
  - R and IEN are retained.
- start:
  - With S=0: S<=1 at the next edge. T0 asserts the cycle after, since SC is already 0.
  - With S=1: ignored.
  - start coinciding with HLT: HLT wins, S=0.
- Simultaneity:
  - Interrupt entry and ION in the same cycle: ION updates IEN; R is set only if IEN was already 1 (the pre-edge value is used).
  - stall high: freezes every update except start.
- Reset mid-instruction: all state returns to reset values immediately, with no completion of the current phase.

Test Plan:
- Reset, S=1, ir=0x2005 (LDA, D2): T steps 01,02,04,08,10,20. sc_clr is high at T5. Next T=01. R=0, IEN=0.
- ir=0x7800 (CLA, D7 I=0 B11): sequence T0..T3, sc_clr at T3, then back to T0. Repeat with ir=0x6000 (ISZ): clears at T6.
- ir=0xF080 (ION) executes to set IEN=1. Raise fgi=1 during the next instruction at T3: R=1 at the following edge. After the instruction, an R cycle T0,T1,T2 runs. At R&T2: R=0, IEN=0, SC=0.
- ir=0x7001 (HLT) at T3: S=0 and T=00 for 10 cycles. Pulse start: S=1, T=01 one cycle later.
- stall=1 for 3 cycles at T1 of LDA: T holds 02 for 4 cycles total, then proceeds to 04. Assert rst_n=0 at T4: T=01 and S=START_RUN asynchronously.
- ir=0xF0C0 (ION and IOF both set) at T3: IEN=0. ION with fgo=1 in the same T3: R stays 0 that edge and is set on the next eligible edge (T4-T7 region or the next instruction's T3).

Source files
------------

// File: rtl/mano_timing_sequencer_if.sv
// Signal bundle between the timing sequencer and the datapath/control blocks.
// The sequencer drives timing and decode every cycle; there is no valid/ready pair.
interface mano_timing_sequencer_if;
    logic [15:0] ir;
    logic        fgi;
    logic        fgo;
    logic        stall;
    logic        start;
    logic [7:0]  T;
    logic [7:0]  D;
    logic        I;
    logic [11:0] B;
    logic        R;
    logic        IEN;
    logic        S;
    logic        sc_clr;
    logic [2:0]  sc;    // raw sequence counter, exposed for debug and checkers

    modport master (
        output ir, fgi, fgo, stall, start,
        input  T, D, I, B, R, IEN, S, sc_clr, sc
    );

    modport slave (
        input  ir, fgi, fgo, stall, start,
        output T, D, I, B, R, IEN, S, sc_clr, sc
    );
endinterface

// File: rtl/mano_timing_sequencer.sv
// Timing and control sequencer for the basic computer: owns SC, S, IEN and R,
// drives the one-hot T phases and decodes IR into D, I and B.
module mano_timing_sequencer #(
    parameter bit START_RUN = 1'b1,
    parameter bit IEN_RESET = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mano_timing_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        PH_T0, PH_T1, PH_T2, PH_T3, PH_T4, PH_T5, PH_T6, PH_T7
    } phase_t;

    phase_t      r_sc;
    phase_t      w_sc_nxt;
    logic        r_s;
    logic        r_r;
    logic        r_ien;
    logic        w_s_nxt;
    logic        w_r_nxt;
    logic        w_ien_nxt;
    logic [7:0]  w_t;
    logic [7:0]  w_d;
    logic        w_i;
    logic [11:0] w_b;
    logic        w_en;
    logic        w_clr;

    assign w_t  = r_s ? (8'b1 << r_sc) : 8'b0;
    assign w_d  = 8'b1 << bus.ir[14:12];
    assign w_i  = bus.ir[15];
    assign w_b  = bus.ir[11:0];
    assign w_en = r_s & ~bus.stall;

    // Last phase of each instruction class, plus the end of the interrupt cycle.
    assign w_clr = (r_r & w_t[2])
                 | ((w_d[0] | w_d[1] | w_d[2] | w_d[5]) & w_t[5])
                 | ((w_d[3] | w_d[4]) & w_t[4])
                 | (w_d[6] & w_t[6])
                 | (w_d[7] & w_t[3]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sc  <= PH_T0;
            r_s   <= START_RUN;
            r_r   <= 1'b0;
            r_ien <= IEN_RESET;
        end else begin
            r_sc  <= w_sc_nxt;
            r_s   <= w_s_nxt;
            r_r   <= w_r_nxt;
            r_ien <= w_ien_nxt;
        end
    end

    always_comb begin
        w_sc_nxt  = r_sc;
        w_s_nxt   = r_s;
        w_r_nxt   = r_r;
        w_ien_nxt = r_ien;
        // start only matters while halted, so it can never race a HLT.
        if (!r_s && bus.start) begin
            w_s_nxt = 1'b1;
        end
        if (w_en) begin
            w_sc_nxt = w_clr ? PH_T0 : phase_t'(r_sc + 3'd1);
            // Entry uses the pre-edge IEN, so an ION in this cycle cannot trigger it.
            if (~w_t[0] & ~w_t[1] & ~w_t[2] & r_ien & (bus.fgi | bus.fgo) & ~r_r) begin
                w_r_nxt = 1'b1;
            end
            if (r_r & w_t[2]) begin
                w_r_nxt   = 1'b0;
                w_ien_nxt = 1'b0;
            end
            if (w_d[7] & w_i & w_t[3]) begin
                if (w_b[7]) w_ien_nxt = 1'b1;
                if (w_b[6]) w_ien_nxt = 1'b0;
            end
            if (w_d[7] & ~w_i & w_t[3] & w_b[0]) begin
                w_s_nxt = 1'b0;
            end
        end
    end

    assign bus.T      = w_t;
    assign bus.D      = w_d;
    assign bus.I      = w_i;
    assign bus.B      = w_b;
    assign bus.R      = r_r;
    assign bus.IEN    = r_ien;
    assign bus.S      = r_s;
    assign bus.sc_clr = w_clr;
    assign bus.sc     = r_sc;

endmodule

// File: tb/tb_mano_timing_sequencer.sv
// Directed bench for mano_timing_sequencer: each driven cycle pushes its expected
// outputs, a negedge monitor pops and compares them.
module tb_mano_timing_sequencer;

  localparam int W = 33;
  localparam logic [15:0] LDA = 16'h2005;
  localparam logic [15:0] CLA = 16'h7800;
  localparam logic [15:0] ISZ = 16'h6000;
  localparam logic [15:0] STA = 16'h3000;
  localparam logic [15:0] ION = 16'hF080;
  localparam logic [15:0] IONOF = 16'hF0C0;
  localparam logic [15:0] HLT = 16'h7001;

  logic clk;
  logic rst_n;
  int checks;
  int errors;
  int step;
  logic [W-1:0] exp_q[$];

  mano_timing_sequencer_if bus();

  mano_timing_sequencer #(.START_RUN(1'b1), .IEN_RESET(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver: apply inputs for one cycle and queue the outputs expected during it
  task automatic cyc(input logic [15:0] ir_v, input logic fgi_v, input logic fgo_v,
                     input logic stall_v, input logic start_v, input logic [7:0] et,
                     input logic eclr, input logic er, input logic eien, input logic es);
    logic [7:0] d;
    d = 8'd1 << ir_v[14:12];
    bus.ir = ir_v;
    bus.fgi = fgi_v;
    bus.fgo = fgo_v;
    bus.stall = stall_v;
    bus.start = start_v;
    exp_q.push_back({et, d, ir_v[15], ir_v[11:0], eclr, er, eien, es});
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.T, bus.D, bus.I, bus.B, bus.sc_clr, bus.R, bus.IEN, bus.S};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL step%0d: got T=%h D=%h I=%b B=%h clr=%b R=%b IEN=%b S=%b, expected T=%h D=%h I=%b B=%h clr=%b R=%b IEN=%b S=%b",
                 step, a[32:25], a[24:17], a[16], a[15:4], a[3], a[2], a[1], a[0],
                 e[32:25], e[24:17], e[16], e[15:4], e[3], e[2], e[1], e[0]);
      end
      step++;
    end
    if (rst_n && bus.S && bus.sc == 3'd7 && !bus.sc_clr) begin
      errors++;
      $display("FAIL sc_wrap: sc=%0d with no clear, expected a clear before T7", bus.sc);
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: queue=%0d, expected 0", exp_q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    checks = 0;
    errors = 0;
    step = 0;
    rst_n = 1'b0;
    bus.ir = LDA;
    bus.fgi = 1'b0;
    bus.fgo = 1'b0;
    bus.stall = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    // reset state
    cyc(LDA, 0, 0, 0, 0, 8'h01, 0, 0, 0, 1);
    rst_n = 1'b1;
    // LDA: memory-reference, clears at T5
    cyc(LDA, 0, 0, 0, 0, 8'h01, 0, 0, 0, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h02, 0, 0, 0, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h04, 0, 0, 0, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h08, 0, 0, 0, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h10, 0, 0, 0, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h20, 1, 0, 0, 1);
    // CLA: register-reference, clears at T3
    cyc(CLA, 0, 0, 0, 0, 8'h01, 0, 0, 0, 1);
    cyc(CLA, 0, 0, 0, 0, 8'h02, 0, 0, 0, 1);
    cyc(CLA, 0, 0, 0, 0, 8'h04, 0, 0, 0, 1);
    cyc(CLA, 0, 0, 0, 0, 8'h08, 1, 0, 0, 1);
    // ISZ clears at T6
    cyc(ISZ, 0, 0, 0, 0, 8'h01, 0, 0, 0, 1);
    cyc(ISZ, 0, 0, 0, 0, 8'h02, 0, 0, 0, 1);
    cyc(ISZ, 0, 0, 0, 0, 8'h04, 0, 0, 0, 1);
    cyc(ISZ, 0, 0, 0, 0, 8'h08, 0, 0, 0, 1);
    cyc(ISZ, 0, 0, 0, 0, 8'h10, 0, 0, 0, 1);
    cyc(ISZ, 0, 0, 0, 0, 8'h20, 0, 0, 0, 1);
    cyc(ISZ, 0, 0, 0, 0, 8'h40, 1, 0, 0, 1);
    // STA clears at T4
    cyc(STA, 0, 0, 0, 0, 8'h01, 0, 0, 0, 1);
    cyc(STA, 0, 0, 0, 0, 8'h02, 0, 0, 0, 1);
    cyc(STA, 0, 0, 0, 0, 8'h04, 0, 0, 0, 1);
    cyc(STA, 0, 0, 0, 0, 8'h08, 0, 0, 0, 1);
    cyc(STA, 0, 0, 0, 0, 8'h10, 1, 0, 0, 1);
    // ION sets IEN at its T3 edge
    cyc(ION, 0, 0, 0, 0, 8'h01, 0, 0, 0, 1);
    cyc(ION, 0, 0, 0, 0, 8'h02, 0, 0, 0, 1);
    cyc(ION, 0, 0, 0, 0, 8'h04, 0, 0, 0, 1);
    cyc(ION, 0, 0, 0, 0, 8'h08, 1, 0, 0, 1);
    // fgi at T3 of LDA raises R; then interrupt cycle T0..T2
    cyc(LDA, 0, 0, 0, 0, 8'h01, 0, 0, 1, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h02, 0, 0, 1, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h04, 0, 0, 1, 1);
    cyc(LDA, 1, 0, 0, 0, 8'h08, 0, 0, 1, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h10, 0, 1, 1, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h20, 1, 1, 1, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h01, 0, 1, 1, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h02, 0, 1, 1, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h04, 1, 1, 1, 1);
    // HLT with a coincident start: HLT wins, then halted for 10 cycles
    cyc(HLT, 0, 0, 0, 0, 8'h01, 0, 0, 0, 1);
    cyc(HLT, 0, 0, 0, 0, 8'h02, 0, 0, 0, 1);
    cyc(HLT, 0, 0, 0, 0, 8'h04, 0, 0, 0, 1);
    cyc(HLT, 0, 0, 0, 1, 8'h08, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(HLT, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    cyc(HLT, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0);
    // restarted: T0 one cycle after start; stall T1 for 3 cycles
    cyc(LDA, 0, 0, 0, 0, 8'h01, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(LDA, 0, 0, 1, 0, 8'h02, 0, 0, 0, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h02, 0, 0, 0, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h04, 0, 0, 0, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h08, 0, 0, 0, 1);
    // SC is now at T4: asynchronous reset with no clock edge in between
    rst_n = 1'b0;
    cyc(LDA, 0, 0, 0, 0, 8'h01, 0, 0, 0, 1);
    rst_n = 1'b1;
    // ION then ION+IOF: IOF wins
    cyc(ION, 0, 0, 0, 0, 8'h01, 0, 0, 0, 1);
    cyc(ION, 0, 0, 0, 0, 8'h02, 0, 0, 0, 1);
    cyc(ION, 0, 0, 0, 0, 8'h04, 0, 0, 0, 1);
    cyc(ION, 0, 0, 0, 0, 8'h08, 1, 0, 0, 1);
    cyc(IONOF, 0, 0, 0, 0, 8'h01, 0, 0, 1, 1);
    cyc(IONOF, 0, 0, 0, 0, 8'h02, 0, 0, 1, 1);
    cyc(IONOF, 0, 0, 0, 0, 8'h04, 0, 0, 1, 1);
    cyc(IONOF, 0, 0, 0, 0, 8'h08, 1, 0, 1, 1);
    // ION with fgo in the same T3: R waits for the next eligible edge
    cyc(ION, 0, 1, 0, 0, 8'h01, 0, 0, 0, 1);
    cyc(ION, 0, 1, 0, 0, 8'h02, 0, 0, 0, 1);
    cyc(ION, 0, 1, 0, 0, 8'h04, 0, 0, 0, 1);
    cyc(ION, 0, 1, 0, 0, 8'h08, 1, 0, 0, 1);
    cyc(LDA, 0, 1, 0, 0, 8'h01, 0, 0, 1, 1);
    cyc(LDA, 0, 1, 0, 0, 8'h02, 0, 0, 1, 1);
    cyc(LDA, 0, 1, 0, 0, 8'h04, 0, 0, 1, 1);
    cyc(LDA, 0, 1, 0, 0, 8'h08, 0, 0, 1, 1);
    cyc(LDA, 0, 1, 0, 0, 8'h10, 0, 1, 1, 1);
    cyc(LDA, 0, 1, 0, 0, 8'h20, 1, 1, 1, 1);
    cyc(LDA, 0, 1, 0, 0, 8'h01, 0, 1, 1, 1);
    cyc(LDA, 0, 1, 0, 0, 8'h02, 0, 1, 1, 1);
    cyc(LDA, 0, 1, 0, 0, 8'h04, 1, 1, 1, 1);
    cyc(LDA, 0, 0, 0, 0, 8'h01, 0, 0, 0, 1);
    // drain
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
